// File: rtl/sram_pkg.sv
// Shared types for the off-chip SRAM bus: widths, access decode and read-pipe beat.
package sram_pkg;

  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_ADDR_W = 18;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_READ,
    SRAM_WRITE
  } sram_access_t;

  typedef struct packed {
    logic                   valid;
    logic [SRAM_DATA_W-1:0] data;
  } sram_rd_beat_t;

  // WE_N low wins over OE_N, so a write and a read can never be decoded together.
  function automatic sram_access_t sram_decode(input logic ce_n, input logic we_n,
                                               input logic oe_n);
    if (ce_n) return SRAM_IDLE;
    if (!we_n) return SRAM_WRITE;
    if (!oe_n) return SRAM_READ;
    return SRAM_IDLE;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-latency shift register of read beats; synchronous active-low clear drops in-flight beats.
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  sram_rd_beat_t beat_i,
  output sram_rd_beat_t head_o
);

  sram_rd_beat_t [Depth-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i].valid <= 1'b0;
      end
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign head_o = stage_q[Depth-1];

endmodule

// File: rtl/sram_device_responder.sv
// Device-side model of a 16-bit async SRAM: byte-lane writes, fixed-latency pipelined reads.
// Optional access counters are built when SRAM_ACCESS_COUNT_EN is defined.
module sram_device_responder
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = 18,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;
  localparam int unsigned LaneW = DATA_W / 2;

  logic [DATA_W-1:0]     mem [Words];
  logic [DEPTH_LOG2-1:0] word_addr;
  sram_access_t          access;
  sram_rd_beat_t         beat_in;
  sram_rd_beat_t         head;
  logic                  drive_en;
  logic                  unused_addr;

  // Upper address bits alias onto the implemented words.
  assign word_addr   = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign unused_addr = ^SRAM_ADDR;
  assign access      = sram_decode(SRAM_CE_N, SRAM_WE_N, SRAM_OE_N);

  always_ff @(posedge clk) begin
    if (access == SRAM_WRITE) begin
      if (!SRAM_UB_N) mem[word_addr][DATA_W-1:LaneW] <= SRAM_DQ[DATA_W-1:LaneW];
      if (!SRAM_LB_N) mem[word_addr][LaneW-1:0]      <= SRAM_DQ[LaneW-1:0];
    end
  end

  always_comb begin
    beat_in.valid = (access == SRAM_READ);
    beat_in.data  = mem[word_addr];
  end

  sram_read_pipe #(
    .Depth(READ_LAT)
  ) u_read_pipe (
    .clk_i (clk),
    .rst_ni(rst),
    .beat_i(beat_in),
    .head_o(head)
  );

  // Drive only while the master is still presenting a read; the pipe never stalls.
  assign drive_en = head.valid && (access == SRAM_READ);

  assign SRAM_DQ[DATA_W-1:LaneW] = (drive_en && !SRAM_UB_N) ? head.data[DATA_W-1:LaneW]
                                                            : {LaneW{1'bz}};
  assign SRAM_DQ[LaneW-1:0]      = (drive_en && !SRAM_LB_N) ? head.data[LaneW-1:0]
                                                            : {LaneW{1'bz}};

`ifdef SRAM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (access == SRAM_READ && rd_count_q != 32'hFFFF_FFFF) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (access == SRAM_WRITE && wr_count_q != 32'hFFFF_FFFF) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule
